// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink-rate detector: rate encoding,
// FSM states and the nominal-period window classifier.
package blink_pkg;

    typedef enum logic [1:0] {
        RATE_1HZ   = 2'b00,
        RATE_10HZ  = 2'b01,
        RATE_50HZ  = 2'b10,
        RATE_100HZ = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    typedef struct packed {
        logic  valid;
        rate_e rate;
    } class_t;

    localparam int unsigned HZ100_P_DEF = 250;
    localparam int unsigned HZ50_P_DEF  = 500;
    localparam int unsigned HZ10_P_DEF  = 2500;
    localparam int unsigned HZ1_P_DEF   = 25000;

    // Window is +/- nom/8 around the nominal period, inclusive.
    function automatic logic in_window(input int unsigned per, input int unsigned nom);
        int unsigned diff;
        diff = (per > nom) ? (per - nom) : (nom - per);
        return diff <= (nom >> 3);
    endfunction

    function automatic class_t classify(
        input int unsigned per,
        input int unsigned p100 = HZ100_P_DEF,
        input int unsigned p50  = HZ50_P_DEF,
        input int unsigned p10  = HZ10_P_DEF,
        input int unsigned p1   = HZ1_P_DEF
    );
        class_t c;
        c.valid = 1'b1;
        c.rate  = RATE_1HZ;
        if (in_window(per, p100))     c.rate = RATE_100HZ;
        else if (in_window(per, p50)) c.rate = RATE_50HZ;
        else if (in_window(per, p10)) c.rate = RATE_10HZ;
        else if (in_window(per, p1))  c.rate = RATE_1HZ;
        else                          c.valid = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/blink_rate_detector_sync_rise.sv
// Two-flop synchronizer for the asynchronous blink line followed by a
// single-cycle rising-edge pulse.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic sync1, sync2, sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/blink_rate_detector.sv
// Measures the clk count between rising edges of a blink line and locks
// onto one of the four standard blink rates.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no activity; next rising edge only re-arms the counter
// ST_MEASURE | periods being classified, waiting for LOCK_N matches
// ST_LOCKED  | rate_code valid, every period still matches the locked rate
module blink_rate_detector
    import blink_pkg::*;
#(
    parameter int HZ100_P = 250,
    parameter int HZ50_P  = 500,
    parameter int HZ10_P  = 2500,
    parameter int HZ1_P   = 25000,
    parameter int TIMEOUT = 50000,
    parameter int LOCK_N  = 2,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          blink_in,
    output logic [1:0]    rate_code,
    output logic          rate_valid,
    output logic [CW-1:0] period,
    output logic          period_stb,
    output logic          err_stb,
    output logic          idle
);

    localparam int MW = $clog2(LOCK_N + 2);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    state_e          state, state_nx;
    rate_e           cand, cand_nx, code_q, code_nx;
    logic [MW-1:0]   match, match_nx, new_match;
    logic [CW-1:0]   cnt, meas, period_nx;
    logic            pstb_nx, estb_nx;
    logic            rise_edge, timeout;
    class_t          cls;

    sync_rise u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (blink_in),
        .rise (rise_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (rise_edge)  cnt <= '0;
        else if (cnt != TO)  cnt <= cnt + 1'b1;
    end

    // A saturated counter reports TIMEOUT itself, which always falls outside
    // every window and therefore flags an error.
    assign timeout = (cnt == TO);
    assign meas    = timeout ? TO : cnt + 1'b1;
    assign cls     = classify(32'(meas), HZ100_P, HZ50_P, HZ10_P, HZ1_P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cand       <= RATE_1HZ;
            match      <= '0;
            code_q     <= RATE_1HZ;
            period     <= '0;
            period_stb <= 1'b0;
            err_stb    <= 1'b0;
        end else begin
            state      <= state_nx;
            cand       <= cand_nx;
            match      <= match_nx;
            code_q     <= code_nx;
            period     <= period_nx;
            period_stb <= pstb_nx;
            err_stb    <= estb_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cand_nx   = cand;
        match_nx  = match;
        code_nx   = code_q;
        period_nx = period;
        pstb_nx   = 1'b0;
        estb_nx   = 1'b0;
        new_match = (cls.valid && cls.rate == cand) ? match + 1'b1 : MW'(1);
        case (state)
            ST_IDLE: begin
                if (rise_edge) begin
                    state_nx = ST_MEASURE;
                    match_nx = '0;
                end
            end
            ST_MEASURE: begin
                if (rise_edge) begin
                    pstb_nx   = 1'b1;
                    period_nx = meas;
                    if (!cls.valid) begin
                        estb_nx  = 1'b1;
                        match_nx = '0;
                    end else begin
                        cand_nx  = cls.rate;
                        match_nx = new_match;
                        if (new_match >= MW'(LOCK_N)) begin
                            state_nx = ST_LOCKED;
                            code_nx  = cls.rate;
                        end
                    end
                end else if (timeout) begin
                    state_nx = ST_IDLE;
                    match_nx = '0;
                end
            end
            ST_LOCKED: begin
                if (rise_edge) begin
                    pstb_nx   = 1'b1;
                    period_nx = meas;
                    if (!cls.valid) begin
                        state_nx = ST_MEASURE;
                        estb_nx  = 1'b1;
                        match_nx = '0;
                    end else if (cls.rate != code_q) begin
                        state_nx = ST_MEASURE;
                        cand_nx  = cls.rate;
                        match_nx = MW'(1);
                    end
                end else if (timeout) begin
                    state_nx = ST_IDLE;
                    match_nx = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rate_valid = (state == ST_LOCKED);
        idle       = (state == ST_IDLE);
        rate_code  = code_q;
    end

endmodule

// File: tb/tb_blink_rate_detector.sv
// Self-checking bench for blink_rate_detector, run with periods scaled down
// by ten so the 1 Hz lock and the timeout fit in a short simulation.
module tb_blink_rate_detector;

    localparam int P100 = 25;
    localparam int P50  = 50;
    localparam int P10  = 250;
    localparam int P1   = 2500;
    localparam int TO   = 5000;
    localparam int LN   = 2;
    localparam int CW   = 16;

    logic          clk;
    logic          rst_n;
    logic          blink_in;
    logic [1:0]    rate_code;
    logic          rate_valid;
    logic [CW-1:0] period;
    logic          period_stb;
    logic          err_stb;
    logic          idle;

    blink_rate_detector #(
        .HZ100_P(P100), .HZ50_P(P50), .HZ10_P(P10), .HZ1_P(P1),
        .TIMEOUT(TO), .LOCK_N(LN), .CW(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blink_in  (blink_in),
        .rate_code (rate_code),
        .rate_valid(rate_valid),
        .period    (period),
        .period_stb(period_stb),
        .err_stb   (err_stb),
        .idle      (idle)
    );

    typedef struct {
        int         p;
        bit         err;
        bit         valid;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[22];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   last_stb_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input int p, input bit e, input bit v, input logic [1:0] c);
        vec_t r;
        r.p = p; r.err = e; r.valid = v; r.code = c;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every strobe consumes the expectation pushed when its rising edge was driven.
    always @(negedge clk) begin : monitor
        vec_t e;
        if (rst_n && (period_stb || err_stb)) begin
            last_stb_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("period_stb", 32'(period_stb), 32'd1);
                chk("period", 32'(period), 32'(e.p));
                chk("err_stb", 32'(err_stb), 32'(e.err));
                chk("rate_valid", 32'(rate_valid), 32'(e.valid));
                chk("rate_code", 32'(rate_code), 32'(e.code));
            end
        end
    end

    task automatic arm();
        @(posedge clk); #1 blink_in = 1'b1;
    endtask

    // Rising edges are exactly v.p cycles apart; the edge closing the period carries v.
    task automatic send(input vec_t v);
        repeat (v.p / 2) @(posedge clk);
        #1 blink_in = 1'b0;
        repeat (v.p - v.p / 2) @(posedge clk);
        exp_q.push_back(v);
        #1 blink_in = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("strobe_missing", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(25,   0, 0, 2'b00);
        tbl[1]  = mk(25,   0, 1, 2'b11);
        tbl[2]  = mk(25,   0, 1, 2'b11);
        tbl[3]  = mk(25,   0, 1, 2'b11);
        tbl[4]  = mk(250,  0, 0, 2'b11);
        tbl[5]  = mk(250,  0, 1, 2'b01);
        tbl[6]  = mk(25,   0, 0, 2'b01);
        tbl[7]  = mk(50,   0, 0, 2'b01);
        tbl[8]  = mk(25,   0, 0, 2'b01);
        tbl[9]  = mk(50,   0, 0, 2'b01);
        tbl[10] = mk(100,  1, 0, 2'b01);
        tbl[11] = mk(100,  1, 0, 2'b01);
        tbl[12] = mk(22,   0, 0, 2'b01);
        tbl[13] = mk(28,   0, 1, 2'b11);
        tbl[14] = mk(29,   1, 0, 2'b11);
        tbl[15] = mk(21,   1, 0, 2'b11);
        tbl[16] = mk(2500, 0, 0, 2'b11);
        tbl[17] = mk(2500, 0, 1, 2'b00);
        tbl[18] = mk(50,   0, 0, 2'b00);
        tbl[19] = mk(50,   0, 1, 2'b10);
        tbl[20] = mk(50,   0, 0, 2'b00);
        tbl[21] = mk(50,   0, 1, 2'b10);

        blink_in = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rate_code", 32'(rate_code), 32'd0);
        chk("rst_rate_valid", 32'(rate_valid), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_period_stb", 32'(period_stb), 32'd0);
        chk("rst_err_stb", 32'(err_stb), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Lock, rate switch, alternation, errors, window edges, 1 Hz lock.
        arm();
        for (int i = 0; i <= 17; i++) send(tbl[i]);
        drain();
        chk("locked_before_timeout_idle", 32'(idle), 32'd0);

        // Line goes quiet after the 1 Hz lock.
        repeat (P1 / 2) @(posedge clk);
        #1 blink_in = 1'b0;
        wait_cyc(last_stb_cyc + TO - 1);
        chk("pre_timeout_idle", 32'(idle), 32'd0);
        chk("pre_timeout_valid", 32'(rate_valid), 32'd1);
        wait_cyc(last_stb_cyc + TO + 2);
        chk("timeout_idle", 32'(idle), 32'd1);
        chk("timeout_valid", 32'(rate_valid), 32'd0);
        chk("timeout_code_held", 32'(rate_code), 32'd0);

        // Lock at 50 Hz, then reset mid-measurement.
        arm();
        send(tbl[18]);
        send(tbl[19]);
        drain();
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rate_code", 32'(rate_code), 32'd0);
        chk("arst_rate_valid", 32'(rate_valid), 32'd0);
        chk("arst_period", 32'(period), 32'd0);
        chk("arst_period_stb", 32'(period_stb), 32'd0);
        chk("arst_err_stb", 32'(err_stb), 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        blink_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        arm();
        send(tbl[20]);
        send(tbl[21]);
        drain();
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/blink_rate_detector.md
# blink_rate_detector

Receive-side counterpart of the LED blink generator: monitors a single toggling line, measures the clock count between rising edges, and classifies it as one of the four standard blink rates (1/10/50/100 Hz at the 25 kHz system clock). Provides the lock status, the rate code and the raw period. Used for loopback self-test of the blinker and for decoding blink-coded status lines from other boards.

## Interface
- `HZ100_P`, 250: nominal 100 Hz period in clk cycles
- `HZ50_P`, 500: nominal 50 Hz period
- `HZ10_P`, 2500: nominal 10 Hz period
- `HZ1_P`, 25000: nominal 1 Hz period
- `TIMEOUT`, 50000: cycles without a rising edge before returning to idle
- `LOCK_N`, 2: consecutive matching periods required to lock
- `CW`, 16: counter/period width; must hold `TIMEOUT`
- `clk` input 1: system clock, 25 kHz
- `rst_n` input 1: reset; one clock; reset is asynchronous and active-low
- `blink_in` input 1: asynchronous blink line
- `rate_code` output 2: locked rate, encoded {sel0,sel1}: 00=1 Hz, 01=10 Hz, 10=50 Hz, 11=100 Hz
- `rate_valid` output 1: high while LOCKED
- `period` output CW: last measured period, in cycles
- `period_stb` output 1: one-cycle pulse when `period` updates
- `err_stb` output 1: one-cycle pulse when a measured period matches no window
- `idle` output 1: high in IDLE (no activity)

## Operation
- Front end: 2-flop synchronizer, then a rising-edge detector (`edge` = sync2 & ~sync3).
- Counter `cnt`: cleared on each `edge`, otherwise increments and saturates at `TIMEOUT`. Measured period = `cnt`+1 at the edge, i.e. the clk count between consecutive edges. A clean 100 Hz input gives 250.
- Window match: class k when |period − P_k| ≤ P_k>>3, e.g. 100 Hz [219,281], 50 Hz [438,562], 10 Hz [2188,2812], 1 Hz [21875,28125]. No match: invalid.
- State machine (IDLE, MEASURE, LOCKED):
  - IDLE: first `edge` moves to MEASURE and starts the counter; no `period_stb`.
  - MEASURE: each `edge` pulses `period_stb`. Valid class equal to the candidate: `match`++; if `match` reaches `LOCK_N`, go to LOCKED and load `rate_code`. Valid class that differs: candidate = class, `match` = 1. Invalid: pulse `err_stb`, `match` = 0.
  - LOCKED: each `edge` pulses `period_stb`. Same class: stay. Different valid class: go to MEASURE, candidate = new class, `match` = 1. Invalid: go to MEASURE, `err_stb`, `match` = 0.
  - Any non-IDLE state: `cnt` reaching `TIMEOUT` with no edge that cycle goes to IDLE; no strobes.
- `rate_valid` = (state==LOCKED). `rate_code` holds its last locked value outside LOCKED.
- `idle` = (state==IDLE).

## Timing
- Reset values: `rate_code`=00, `rate_valid`=0, `period`=0, `period_stb`=0, `err_stb`=0, `idle`=1, state IDLE, synchronizer flops 0, `cnt`=0, `match`=0.
- Latency: `blink_in` rising sampled at posedge k gives `edge` in cycle k+2; `period_stb`, `err_stb`, `period`, `rate_valid` and `rate_code` are registered and update at posedge k+3.
- Edge and timeout in the same cycle: the edge wins; the period is measured as `TIMEOUT` and classified as invalid (`err_stb`).
- Reset mid-measurement: all state is cleared immediately and asynchronously. After release, the first edge only re-arms.
- Pulse widths on `blink_in` shorter than 2 clk cycles may be missed. This is not an error.

## Structure
- Package `blink_pkg`: `rate_e` (2-bit, {sel0,sel1} encoding), `state_e` (IDLE/MEASURE/LOCKED), nominal period constants, function `classify(period) -> {valid, rate_e}` implementing the >>3 windows.
- Sub-module `sync_rise`: 2-flop synchronizer and rising-edge pulse, with an `rst_n` async clear.

## Test plan
- Square wave with half-period 125 cycles: `period_stb` every 250 cycles with `period`=250. `rate_valid` rises at the third edge (second matching period, `LOCK_N`=2) with `rate_code`=11.
- Switch the source from 100 Hz to 10 Hz (half-period 1250): at the first 2500-cycle period, `rate_valid`=0 and state is MEASURE. Relock with `rate_code`=01 at the next 2500 period.
- Periods of 250, 500, 250, 500 alternating: never locks, `rate_valid` stays 0, no `err_stb`.
- Period of 1000 cycles: `err_stb` on every edge, `period`=1000, `rate_valid`=0.
- Lock at 1 Hz (`rate_code`=00), then hold `blink_in` at 0: `idle`=1 and `rate_valid`=0 exactly `TIMEOUT` cycles after the last edge. No strobes are issued.
- Assert `rst_n` low while locked at 50 Hz: all outputs return to reset values asynchronously. After release, the first edge produces no `period_stb`.
